// File: rtl/parity_pkg.sv
// -----------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the 2-D parity receive stage: frame geometry, result
// status encodings, the receive FSM state type and small one-hot helpers used
// by the syndrome classifier.
// Build option: PARITY_CORRECT_EN (consumed by parity_syndrome / parity_frame_rx).
// -----------------------------------------------------------------------------
package parity_pkg;

  localparam int FRAME_LEN = 24;
  localparam int DATA_W    = 16;
  localparam int MAT_DIM   = 4;

  localparam logic [1:0] ST_OK        = 2'd0;
  localparam logic [1:0] ST_CORRECTED = 2'd1;
  localparam logic [1:0] ST_UNCORR    = 2'd2;
  localparam logic [1:0] ST_PBIT      = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2
  } state_e;

  // True when exactly one bit of a 4-bit syndrome is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Position of the set bit in a one-hot 4-bit syndrome (0 otherwise).
  function automatic logic [1:0] onehot4_idx(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/parity_syndrome.sv
// -----------------------------------------------------------------------------
// parity_syndrome
// Purely combinational 2-D parity check of a 4x4 data matrix.
// Ports:
//   i_data     [15:0] data word, row r = i_data[4r+3:4r]
//   i_row_par  [3:0]  received row parity P_r
//   i_col_par  [3:0]  received column parity P_c
//   o_row_syn  [3:0]  row syndrome (bit r set = row r mismatch)
//   o_col_syn  [3:0]  column syndrome (bit c set = column c mismatch)
//   o_err_pos  [3:0]  single data-error index 4r+c, else 0
//   o_status   [1:0]  ST_OK / ST_CORRECTED / ST_UNCORR / ST_PBIT
// Build option: PARITY_CORRECT_EN selects CORRECTED vs UNCORRECTABLE status
// for a single data-bit error.
// -----------------------------------------------------------------------------
module parity_syndrome
  import parity_pkg::*;
(
  input  logic [15:0] i_data,
  input  logic [3:0]  i_row_par,
  input  logic [3:0]  i_col_par,
  output logic [3:0]  o_row_syn,
  output logic [3:0]  o_col_syn,
  output logic [3:0]  o_err_pos,
  output logic [1:0]  o_status
);

  logic w_row_one;
  logic w_col_one;

  // Recompute even parity per row and per column and fold in the received bits.
  always_comb begin
    o_row_syn = 4'd0;
    o_col_syn = 4'd0;
    for (int r = 0; r < MAT_DIM; r++) begin
      o_row_syn[r] = (^i_data[4*r +: 4]) ^ i_row_par[r];
    end
    for (int c = 0; c < MAT_DIM; c++) begin
      o_col_syn[c] = i_data[c] ^ i_data[c+4] ^ i_data[c+8] ^ i_data[c+12] ^ i_col_par[c];
    end
  end

  assign w_row_one = is_onehot4(o_row_syn);
  assign w_col_one = is_onehot4(o_col_syn);

  // Classify the syndrome pair; a crossing of one row and one column pins a data bit.
  always_comb begin
    o_err_pos = 4'd0;
    o_status  = ST_OK;
    if ((o_row_syn == 4'd0) && (o_col_syn == 4'd0)) begin
      o_status = ST_OK;
    end else if (w_row_one && w_col_one) begin
      o_err_pos = {onehot4_idx(o_row_syn), onehot4_idx(o_col_syn)};
`ifdef PARITY_CORRECT_EN
      o_status  = ST_CORRECTED;
`else
      o_status  = ST_UNCORR;
`endif
    end else if ((w_row_one && (o_col_syn == 4'd0)) || (w_col_one && (o_row_syn == 4'd0))) begin
      o_status = ST_PBIT;
    end else begin
      o_status = ST_UNCORR;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// -----------------------------------------------------------------------------
// parity_frame_rx
// Serial receiver for 24-bit 2-D parity frames (16 data + 4 row + 4 column
// parity bits, LSB first). Produces a one-cycle result strobe with the data
// word, syndromes, error position and status, plus a saturating count of
// frames with a non-OK status.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bit_in, bit_vld   serial bit and its qualifier
//   sof               frame start, meaningful only with bit_vld
//   busy              frame being shifted or checked
//   out_valid         one-cycle result strobe
//   data_out[15:0]    received word (corrected when enabled)
//   row_syn, col_syn  4-bit row/column syndromes
//   err_pos[3:0]      single data-error index 4r+c, else 0
//   status[1:0]       0 OK, 1 CORRECTED, 2 UNCORRECTABLE, 3 PARITY_BIT_ERR
//   err_cnt           saturating count of frames with status != 0
// Build option: PARITY_CORRECT_EN -- when defined a single data-bit error is
// inverted back in data_out; when undefined no correction logic is built.
// -----------------------------------------------------------------------------
module parity_frame_rx
  import parity_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_vld,
  input  logic                 sof,
  output logic                 busy,
  output logic                 out_valid,
  output logic [15:0]          data_out,
  output logic [3:0]           row_syn,
  output logic [3:0]           col_syn,
  output logic [3:0]           err_pos,
  output logic [1:0]           status,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [4:0] LAST_BIT = 5'(FRAME_LEN - 1);

  state_e                 r_state;
  logic [4:0]             r_bit_cnt;
  logic [23:0]            r_frame;
  logic                   r_busy;
  logic                   r_out_valid;
  logic [15:0]            r_data_out;
  logic [3:0]             r_row_syn;
  logic [3:0]             r_col_syn;
  logic [3:0]             r_err_pos;
  logic [1:0]             r_status;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  logic [3:0]             w_row_syn;
  logic [3:0]             w_col_syn;
  logic [3:0]             w_err_pos;
  logic [1:0]             w_status;
  logic [15:0]            w_data_fix;
  logic [23:0]            w_frame_shift;

  // Bits enter at the top so frame bit 0 ends up at r_frame[0] after 24 shifts.
  assign w_frame_shift = {bit_in, r_frame[23:1]};

  parity_syndrome u_syndrome (
    .i_data    (r_frame[15:0]),
    .i_row_par (r_frame[19:16]),
    .i_col_par (r_frame[23:20]),
    .o_row_syn (w_row_syn),
    .o_col_syn (w_col_syn),
    .o_err_pos (w_err_pos),
    .o_status  (w_status)
  );

`ifdef PARITY_CORRECT_EN
  // Flip the located data bit back when the classifier reports a correctable error.
  always_comb begin
    w_data_fix = r_frame[15:0];
    if (w_status == ST_CORRECTED) begin
      w_data_fix = r_frame[15:0] ^ (16'd1 << w_err_pos);
    end else begin
      w_data_fix = r_frame[15:0];
    end
  end
`else
  // No correction path: the received word is passed through as-is.
  always_comb begin
    w_data_fix = r_frame[15:0];
  end
`endif

  // Receive FSM, bit counter and shift register; sof in SHIFT restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 5'd0;
      r_frame   <= 24'd0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bit_vld && sof) begin
            r_frame   <= w_frame_shift;
            r_bit_cnt <= 5'd1;
            r_busy    <= 1'b1;
            r_state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (bit_vld) begin
            r_frame <= w_frame_shift;
            if (sof) begin
              r_bit_cnt <= 5'd1;
            end else if (r_bit_cnt == LAST_BIT) begin
              r_bit_cnt <= 5'd0;
              r_state   <= S_CHECK;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        S_CHECK: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_bit_cnt <= 5'd0;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Result registers and saturating error counter, loaded on the CHECK cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_data_out  <= 16'd0;
      r_row_syn   <= 4'd0;
      r_col_syn   <= 4'd0;
      r_err_pos   <= 4'd0;
      r_status    <= ST_OK;
      r_err_cnt   <= {ERR_CNT_W{1'b0}};
    end else begin
      r_out_valid <= (r_state == S_CHECK);
      if (r_state == S_CHECK) begin
        r_data_out <= w_data_fix;
        r_row_syn  <= w_row_syn;
        r_col_syn  <= w_col_syn;
        r_err_pos  <= w_err_pos;
        r_status   <= w_status;
        if ((w_status != ST_OK) && !(&r_err_cnt)) begin
          r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
        end
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign data_out  = r_data_out;
  assign row_syn   = r_row_syn;
  assign col_syn   = r_col_syn;
  assign err_pos   = r_err_pos;
  assign status    = r_status;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_parity_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_parity_frame_rx
// Randomised and directed stimulus for parity_frame_rx against a behavioural
// matrix-parity model. Works in both builds (PARITY_CORRECT_EN on or off).
// -----------------------------------------------------------------------------
module tb_parity_frame_rx;

  localparam int CW  = 8;
  localparam int INF = 32'h7fff_ffff;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_in;
  logic          bit_vld;
  logic          sof;
  logic          busy;
  logic          out_valid;
  logic [15:0]   data_out;
  logic [3:0]    row_syn;
  logic [3:0]    col_syn;
  logic [3:0]    err_pos;
  logic [1:0]    status;
  logic [CW-1:0] err_cnt;

  parity_frame_rx #(.ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .sof       (sof),
    .busy      (busy),
    .out_valid (out_valid),
    .data_out  (data_out),
    .row_syn   (row_syn),
    .col_syn   (col_syn),
    .err_pos   (err_pos),
    .status    (status),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  rs;
    logic [3:0]  cs;
    logic [3:0]  pos;
    logic [1:0]  st;
  } res_t;

  typedef struct {
    res_t r;
    int   due;
  } pend_t;

  int            cyc = 0;
  int            n_cmp = 0;
  int            n_fail = 0;
  int            ov_seen = 0;
  int            busy_from = INF;
  int            busy_until = INF;
  bit            run_chk = 1'b0;
  bit            exp_ov;
  pend_t         q[$];
  res_t          m_last;
  logic [CW-1:0] m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference: view the word as a 4x4 matrix and count mismatching rows/cols.
  function automatic res_t model(input logic [15:0] d, input logic [3:0] pr, input logic [3:0] pc);
    res_t res;
    logic [3:0] rowx = 4'd0;
    logic [3:0] colx = 4'd0;
    int nr, nc, rr, cc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        rowx[r] = rowx[r] ^ d[4*r+c];
        colx[c] = colx[c] ^ d[4*r+c];
      end
    res.rs   = rowx ^ pr;
    res.cs   = colx ^ pc;
    res.data = d;
    res.pos  = 4'd0;
    nr = $countones(res.rs);
    nc = $countones(res.cs);
    rr = 0;
    cc = 0;
    for (int i = 0; i < 4; i++) begin
      if (res.rs[i]) rr = i;
      if (res.cs[i]) cc = i;
    end
    if (nr == 0 && nc == 0) res.st = 2'd0;
    else if (nr == 1 && nc == 1) begin
      res.pos = 4'(4 * rr + cc);
`ifdef PARITY_CORRECT_EN
      res.data = d ^ (16'd1 << res.pos);
      res.st   = 2'd1;
`else
      res.st   = 2'd2;
`endif
    end else if (nr + nc == 1) res.st = 2'd3;
    else res.st = 2'd2;
    return res;
  endfunction

  function automatic logic [23:0] clean_frame(input logic [15:0] d);
    res_t p;
    p = model(d, 4'd0, 4'd0);
    return {p.cs, p.rs, d};
  endfunction

  // Per-cycle comparison of every output against the model, one edge after it settles.
  always @(posedge clk) begin
    #1;
    if (run_chk) begin
      exp_ov = (q.size() > 0) && (q[0].due == cyc);
      if (exp_ov) begin
        m_last = q[0].r;
        void'(q.pop_front());
        if (m_last.st != 2'd0 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + CW'(1);
      end
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      if (out_valid === 1'b1) ov_seen++;
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("data_out",  32'(data_out),  32'(m_last.data));
      chk("row_syn",   32'(row_syn),   32'(m_last.rs));
      chk("col_syn",   32'(col_syn),   32'(m_last.cs));
      chk("err_pos",   32'(err_pos),   32'(m_last.pos));
      chk("status",    32'(status),    32'(m_last.st));
      chk("err_cnt",   32'(err_cnt),   32'(m_cnt));
      chk("busy",      32'(busy),      32'((cyc >= busy_from) && (cyc < busy_until)));
    end
  end

  // One clock of input drive, starting and ending at a falling edge.
  task automatic drive(input bit v, input bit b, input bit s);
    bit_vld = v;
    bit_in  = b;
    sof     = s;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit noise);
    for (int k = 0; k < n; k++) drive(noise ? 1'($urandom) : 1'b0, 1'($urandom), 1'b0);
  endtask

  // Send the first nbits of a frame; accepted=0 means its sof falls where it is ignored.
  task automatic send_frame(input logic [23:0] fr, input int nbits, input int maxgap, input bit accepted);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat ($urandom_range(maxgap, 0)) drive(1'b0, 1'($urandom), 1'($urandom));
      if (accepted && i == 0) begin
        busy_from  = cyc + 1;
        busy_until = INF;
      end
      if (accepted && i == 23) begin
        q.push_back('{r: model(fr[15:0], fr[19:16], fr[23:20]), due: cyc + 2});
        busy_until = cyc + 2;
      end
      drive(1'b1, fr[i], i == 0);
    end
    bit_vld = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    q.delete();
    m_last     = '{data: 16'd0, rs: 4'd0, cs: 4'd0, pos: 4'd0, st: 2'd0};
    m_cnt      = '0;
    busy_from  = INF;
    busy_until = INF;
    idle(n, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] d, input logic [3:0] rs,
                          input logic [3:0] cs, input logic [3:0] pos, input logic [1:0] st,
                          input logic [CW-1:0] cnt);
    chk({tag, ".data"},   32'(data_out), 32'(d));
    chk({tag, ".row"},    32'(row_syn),  32'(rs));
    chk({tag, ".col"},    32'(col_syn),  32'(cs));
    chk({tag, ".pos"},    32'(err_pos),  32'(pos));
    chk({tag, ".status"}, 32'(status),   32'(st));
    chk({tag, ".cnt"},    32'(err_cnt),  32'(cnt));
  endtask

  res_t        pin;
  logic [23:0] fr;
  logic [15:0] rd;
  int          ov0;

  initial begin
    rst_n = 1'b0; bit_in = 1'b0; bit_vld = 1'b0; sof = 1'b0;
    m_last = '{data: 16'd0, rs: 4'd0, cs: 4'd0, pos: 4'd0, st: 2'd0};
    m_cnt  = '0;
    repeat (3) @(negedge clk);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk_outs("reset", 16'h0000, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_chk = 1'b1;

    // Pin the model on hand-computed cases.
    pin = model(16'hA5C3, 4'd0, 4'd0);
    chk("model.clean.st", 32'(pin.st), 32'd0);
    pin = model(16'hA7C3, 4'd0, 4'd0);
    chk("model.b9.row", 32'(pin.rs), 32'b0100);
    chk("model.b9.col", 32'(pin.cs), 32'b0010);
    chk("model.b9.pos", 32'(pin.pos), 32'd9);
    pin = model(16'hA5C3, 4'b0010, 4'd0);
    chk("model.pbit.st", 32'(pin.st), 32'd3);
    pin = model(16'hA5E2, 4'd0, 4'd0);
    chk("model.dbl.st", 32'(pin.st), 32'd2);
    chk("model.dbl.pos", 32'(pin.pos), 32'd0);

    // Directed cases from the hand-worked frame 0xA5C3.
    send_frame({8'h00, 16'hA5C3}, 24, 1, 1'b1);
    idle(3, 1'b0);
    chk_outs("clean", 16'hA5C3, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0);

    send_frame({8'h00, 16'hA7C3}, 24, 1, 1'b1);
    idle(3, 1'b0);
`ifdef PARITY_CORRECT_EN
    chk_outs("bit9", 16'hA5C3, 4'b0100, 4'b0010, 4'd9, 2'd1, 8'd1);
`else
    chk_outs("bit9", 16'hA7C3, 4'b0100, 4'b0010, 4'd9, 2'd2, 8'd1);
`endif

    send_frame({4'd0, 4'b0010, 16'hA5C3}, 24, 0, 1'b1);
    idle(3, 1'b0);
    chk_outs("pbit", 16'hA5C3, 4'b0010, 4'd0, 4'd0, 2'd3, 8'd2);

    send_frame({8'h00, 16'hA5E2}, 24, 2, 1'b1);
    idle(3, 1'b0);
    chk_outs("dbl", 16'hA5E2, 4'b0011, 4'b0011, 4'd0, 2'd2, 8'd3);

    // Abort at bit 10, then a full frame: only the second frame reports.
    ov0 = ov_seen;
    send_frame(24'hFFFFFF, 10, 1, 1'b1);
    send_frame({8'h00, 16'h1234} | clean_frame(16'h1234), 24, 1, 1'b1);
    idle(3, 1'b0);
    chk("abort.count", 32'(ov_seen - ov0), 32'd1);

    // Second frame's sof lands on the CHECK cycle and must be lost.
    ov0 = ov_seen;
    send_frame(clean_frame(16'hBEEF), 24, 0, 1'b1);
    send_frame(clean_frame(16'h0F0F) ^ 24'h000001, 24, 0, 1'b0);
    idle(3, 1'b0);
    chk("lost.count", 32'(ov_seen - ov0), 32'd1);

    // Reset mid-frame: no report, everything cleared.
    ov0 = ov_seen;
    send_frame(clean_frame(16'h5555), 12, 1, 1'b1);
    do_reset(2);
    idle(30, 1'b1);
    chk("rst.count", 32'(ov_seen - ov0), 32'd0);
    chk_outs("rst", 16'h0000, 4'd0, 4'd0, 4'd0, 2'd0, 8'd0);

    // Randomised frames with assorted corruptions, aborts and gaps.
    for (int n = 0; n < 150; n++) begin
      rd = 16'($urandom);
      fr = clean_frame(rd);
      case ($urandom_range(3, 0))
        0: ;
        1: fr[$urandom_range(23, 0)] ^= 1'b1;
        2: begin
          fr[$urandom_range(23, 0)] ^= 1'b1;
          fr[$urandom_range(23, 0)] ^= 1'b1;
        end
        default: fr = 24'($urandom);
      endcase
      if ($urandom_range(7, 0) == 0) send_frame(24'($urandom), $urandom_range(23, 1), 1, 1'b1);
      send_frame(fr, 24, 2, 1'b1);
      idle($urandom_range(3, 1), 1'b1);
    end

    // Counter saturation: far more error frames than the counter can hold.
    for (int n = 0; n < (1 << CW) + 2; n++) begin
      send_frame(clean_frame(16'($urandom)) ^ 24'h000001, 24, 0, 1'b1);
      idle(1, 1'b0);
    end
    idle(3, 1'b0);
    chk("sat.cnt", 32'(err_cnt), 32'({CW{1'b1}}));

    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
